// File: rtl/bullet_if.sv
// ---------------------------------------------------------------------------
// bullet_if
// Purpose : groups the battle-box control inputs and the per-slot bullet
//           outputs of the enemy-projectile generator into one bundle.
// Signals : index1/index2   pattern select per slot (3 bits)
//           isRun           battle active
//           isCollide       heart hit any bullet (level, sampled on clk)
//           position1/2     {x[15:8], y[7:0]} top-left corner
//           size1/2         {w[15:8], h[7:0]}
//           color1/2        000 white, 001 green, 010 blue
//           isRender1/2     slot visible and harmful
// Modports: master drives the controls and observes the bullets;
//           slave is the generator side.
// ---------------------------------------------------------------------------
interface bullet_if;
    logic [2:0]  index1;
    logic [2:0]  index2;
    logic        isRun;
    logic        isCollide;
    logic [15:0] position1;
    logic [15:0] size1;
    logic [2:0]  color1;
    logic        isRender1;
    logic [15:0] position2;
    logic [15:0] size2;
    logic [2:0]  color2;
    logic        isRender2;

    modport master (
        output index1, index2, isRun, isCollide,
        input  position1, size1, color1, isRender1,
        input  position2, size2, color2, isRender2
    );

    modport slave (
        input  index1, index2, isRun, isCollide,
        output position1, size1, color1, isRender1,
        output position2, size2, color2, isRender2
    );
endinterface

// File: rtl/bullet.sv
// ---------------------------------------------------------------------------
// bullet
// Purpose : enemy-projectile generator for the battle box. Two independent
//           bullet slots, each following a motion pattern chosen by a 3-bit
//           index. Motion advances on a prescaled tick while the battle runs;
//           a heart collision hides the live bullets and respawns them after
//           RESPAWN_TICKS ticks.
// Ports   : clk    system clock, rising edge
//           rst_n  asynchronous active-low reset
//           bus    bullet_if.slave (controls in, per-slot bullet outputs)
// ---------------------------------------------------------------------------
module bullet #(
    parameter int TICK_DIV      = 4,
    parameter int X0            = 40,
    parameter int X1            = 200,
    parameter int Y0            = 40,
    parameter int Y1            = 200,
    parameter int OFFSET2       = 40,
    parameter int RESPAWN_TICKS = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    bullet_if.slave  bus
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [7:0] BX0  = 8'(X0);
    localparam logic [7:0] BX1  = 8'(X1);
    localparam logic [7:0] BY0  = 8'(Y0);
    localparam logic [7:0] BOFF = 8'(OFFSET2);

    localparam logic signed [8:0] SX0 = 9'(X0);
    localparam logic signed [8:0] SX1 = 9'(X1);
    localparam logic signed [8:0] SY0 = 9'(Y0);
    localparam logic signed [8:0] SY1 = 9'(Y1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_HIDDEN
    } state_t;

    // vx/vy are 3-bit two's complement velocities per tick
    typedef struct packed {
        logic       valid;
        logic       bounce;
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] w;
        logic [7:0] h;
        logic [2:0] color;
        logic [2:0] vx;
        logic [2:0] vy;
    } pat_t;

    function automatic pat_t pattern_lookup(input logic [2:0] idx, input logic slot2);
        pat_t p;
        p = '0;
        case (idx)
            3'd0: begin
                p.valid = 1'b1; p.x = BX0;         p.y = BY0 + 8'd16;
                p.w = 8'd8;     p.h = 8'd8;        p.color = 3'b000;
                p.vx = 3'd1;    p.vy = 3'd0;
            end
            3'd1: begin
                p.valid = 1'b1; p.x = BX0 + 8'd32; p.y = BY0;
                p.w = 8'd16;    p.h = 8'd4;        p.color = 3'b001;
                p.vx = 3'd0;    p.vy = 3'd1;
            end
            3'd2: begin
                p.valid = 1'b1; p.x = BX0;         p.y = BY0;
                p.w = 8'd6;     p.h = 8'd6;        p.color = 3'b000;
                p.vx = 3'd1;    p.vy = 3'd1;
            end
            3'd3: begin
                p.valid = 1'b1; p.x = BX1 - 8'd4;  p.y = BY0;
                p.w = 8'd4;     p.h = 8'd32;       p.color = 3'b010;
                p.vx = 3'b110;  p.vy = 3'd0;
            end
            3'd4: begin
                p.valid = 1'b1; p.x = BX0 + 8'd64; p.y = BY0;
                p.w = 8'd8;     p.h = 8'd8;        p.color = 3'b000;
                p.vx = 3'd0;    p.vy = 3'd2;       p.bounce = 1'b1;
            end
            default: ;
        endcase
        // slot 2 is offset perpendicular to its direction of motion
        if (slot2 && p.valid) begin
            if (idx == 3'd0 || idx == 3'd3) p.y = p.y + BOFF;
            else                            p.x = p.x + BOFF;
        end
        return p;
    endfunction

    // {valid, spawn x, spawn y} of a pattern
    function automatic logic [16:0] spawn_of(input logic [2:0] idx, input logic slot2);
        pat_t p;
        p = pattern_lookup(idx, slot2);
        return {p.valid, p.x, p.y};
    endfunction

    // ---------------------------------------------------------------- tick
    logic [CW-1:0] r_tick_cnt;
    logic          w_tick;

    assign w_tick = bus.isRun && (r_tick_cnt == CW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      r_tick_cnt <= '0;
        else if (!bus.isRun || w_tick)   r_tick_cnt <= '0;
        else                             r_tick_cnt <= r_tick_cnt + 1'b1;
    end

    // ---------------------------------------------------------------- slots
    logic [2:0]  w_index  [2];
    logic [15:0] w_pos    [2];
    logic [15:0] w_size   [2];
    logic [2:0]  w_color  [2];
    logic        w_render [2];

    assign w_index[0] = bus.index1;
    assign w_index[1] = bus.index2;

    for (genvar s = 0; s < 2; s++) begin : g_slot
        localparam logic SLOT2 = (s == 1);

        state_t            r_state, w_state_nxt;
        logic [2:0]        r_idx,   w_idx_nxt;
        logic [7:0]        r_x,     w_x_nxt;
        logic [7:0]        r_y,     w_y_nxt;
        logic              r_down,  w_down_nxt;
        logic              r_render, w_render_nxt;
        logic [7:0]        r_rcnt,  w_rcnt_nxt;

        pat_t              w_cur;
        logic [16:0]       w_new;
        logic signed [8:0] w_vy;
        logic signed [8:0] w_mx;
        logic signed [8:0] w_my;
        logic [7:0]        w_by;
        logic              w_leave;
        logic              w_turn;

        assign w_cur = pattern_lookup(r_idx, SLOT2);
        assign w_new = spawn_of(w_index[s], SLOT2);

        // candidate move; w_by is the reversed step used when a bouncer turns
        always_comb begin
            w_vy = $signed({{6{w_cur.vy[2]}}, w_cur.vy});
            if (r_down) w_vy = -w_vy;
            w_mx = $signed({1'b0, r_x}) + $signed({{6{w_cur.vx[2]}}, w_cur.vx});
            w_my = $signed({1'b0, r_y}) + w_vy;
            w_by = r_y - w_vy[7:0];
            w_leave = (w_mx < SX0) || (w_mx + $signed({1'b0, w_cur.w}) > SX1) ||
                      (w_my < SY0) || (w_my + $signed({1'b0, w_cur.h}) > SY1);
            w_turn  = (w_my < SY0) || (w_my > SY1 - $signed({1'b0, w_cur.h}));
        end

        always_comb begin
            w_state_nxt  = r_state;
            w_idx_nxt    = r_idx;
            w_x_nxt      = r_x;
            w_y_nxt      = r_y;
            w_down_nxt   = r_down;
            w_render_nxt = r_render;
            w_rcnt_nxt   = r_rcnt;

            if (!bus.isRun) begin
                w_state_nxt  = S_IDLE;
                w_render_nxt = 1'b0;
                w_rcnt_nxt   = '0;
            end else if (w_index[s] != r_idx) begin
                w_idx_nxt  = w_index[s];
                w_rcnt_nxt = '0;
                w_down_nxt = 1'b0;
                if (w_new[16]) begin
                    w_state_nxt  = S_ACTIVE;
                    w_x_nxt      = w_new[15:8];
                    w_y_nxt      = w_new[7:0];
                    w_render_nxt = 1'b1;
                end else begin
                    w_state_nxt  = S_IDLE;
                    w_x_nxt      = '0;
                    w_y_nxt      = '0;
                    w_render_nxt = 1'b0;
                end
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_cur.valid) begin
                            w_state_nxt  = S_ACTIVE;
                            w_x_nxt      = w_cur.x;
                            w_y_nxt      = w_cur.y;
                            w_down_nxt   = 1'b0;
                            w_render_nxt = 1'b1;
                            w_rcnt_nxt   = '0;
                        end
                    end
                    S_ACTIVE: begin
                        if (bus.isCollide) begin
                            w_state_nxt  = S_HIDDEN;
                            w_x_nxt      = w_cur.x;
                            w_y_nxt      = w_cur.y;
                            w_down_nxt   = 1'b0;
                            w_render_nxt = 1'b0;
                            w_rcnt_nxt   = '0;
                        end else if (w_tick) begin
                            if (w_cur.bounce) begin
                                w_x_nxt = w_mx[7:0];
                                if (w_turn) begin
                                    w_y_nxt    = w_by;
                                    w_down_nxt = !r_down;
                                end else begin
                                    w_y_nxt = w_my[7:0];
                                end
                            end else if (w_leave) begin
                                w_x_nxt = w_cur.x;
                                w_y_nxt = w_cur.y;
                            end else begin
                                w_x_nxt = w_mx[7:0];
                                w_y_nxt = w_my[7:0];
                            end
                        end
                    end
                    S_HIDDEN: begin
                        if (w_tick) begin
                            if (r_rcnt == 8'(RESPAWN_TICKS - 1)) begin
                                w_state_nxt  = S_ACTIVE;
                                w_render_nxt = 1'b1;
                                w_rcnt_nxt   = '0;
                            end else begin
                                w_rcnt_nxt = r_rcnt + 8'd1;
                            end
                        end
                    end
                    default: w_state_nxt = S_IDLE;
                endcase
            end
        end

        // latched index resets to a disabled pattern so size/colour read 0
        // in reset and the first valid index is taken as an index change
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state  <= S_IDLE;
                r_idx    <= 3'd7;
                r_x      <= '0;
                r_y      <= '0;
                r_down   <= 1'b0;
                r_render <= 1'b0;
                r_rcnt   <= '0;
            end else begin
                r_state  <= w_state_nxt;
                r_idx    <= w_idx_nxt;
                r_x      <= w_x_nxt;
                r_y      <= w_y_nxt;
                r_down   <= w_down_nxt;
                r_render <= w_render_nxt;
                r_rcnt   <= w_rcnt_nxt;
            end
        end

        assign w_pos[s]    = {r_x, r_y};
        assign w_size[s]   = {w_cur.w, w_cur.h};
        assign w_color[s]  = w_cur.color;
        assign w_render[s] = r_render;
    end

    assign bus.position1 = w_pos[0];
    assign bus.size1     = w_size[0];
    assign bus.color1    = w_color[0];
    assign bus.isRender1 = w_render[0];
    assign bus.position2 = w_pos[1];
    assign bus.size2     = w_size[1];
    assign bus.color2    = w_color[1];
    assign bus.isRender2 = w_render[1];

endmodule

// File: tb/tb_bullet.sv
// ---------------------------------------------------------------------------
// tb_bullet
// Purpose : directed self-checking bench for bullet. Edge count e is the
//           number of rising edges since reset release; with TICK_DIV=4 a
//           movement tick lands on every edge where e is a multiple of 4
//           while isRun stays high.
// ---------------------------------------------------------------------------
module tb_bullet;
    logic clk = 1'b0;
    logic rst_n;
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int e = 0;

    bullet_if bus();

    bullet #(
        .TICK_DIV(4), .X0(40), .X1(200), .Y0(40), .Y1(200),
        .OFFSET2(40), .RESPAWN_TICKS(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, e);
        end
    endtask

    // advance to 1 ns after rising edge number 'target'
    task automatic goto(input int target);
        while (e < target) begin
            @(posedge clk);
            #1;
            e++;
        end
    endtask

    function automatic logic [15:0] xy(input int x, input int y);
        return {8'(x), 8'(y)};
    endfunction

    initial begin
        bus.index1    = 3'd0;
        bus.index2    = 3'd0;
        bus.isRun     = 1'b1;
        bus.isCollide = 1'b0;
        rst_n         = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst pos1",    bus.position1, 16'h0000);
        check("rst pos2",    bus.position2, 16'h0000);
        check("rst size1",   bus.size1, 16'h0000);
        check("rst color1",  16'(bus.color1), 16'h0000);
        check("rst render1", 16'(bus.isRender1), 16'h0000);
        check("rst render2", 16'(bus.isRender2), 16'h0000);
        rst_n = 1'b1;

        // spawn one edge after release
        goto(1);
        check("start pos1",    bus.position1, xy(40, 56));
        check("start pos2",    bus.position2, xy(40, 96));
        check("start render1", 16'(bus.isRender1), 16'h0001);
        check("start render2", 16'(bus.isRender2), 16'h0001);
        check("start size1",   bus.size1, 16'h0808);
        check("start size2",   bus.size2, 16'h0808);
        check("start color1",  16'(bus.color1), 16'h0000);

        // pattern 0 motion
        goto(3);   check("pre tick pos1", bus.position1, xy(40, 56));
        goto(4);   check("tick1 pos1",    bus.position1, xy(41, 56));
        goto(40);  check("tick10 pos1",   bus.position1, xy(50, 56));
        goto(611); check("edge pos1",     bus.position1, xy(192, 56));
        goto(612); check("wrap pos1",     bus.position1, xy(40, 56));
        check("wrap pos2", bus.position2, xy(40, 96));
        goto(622); check("pre hit pos1",  bus.position1, xy(42, 56));

        // collision across exactly one rising edge
        bus.isCollide = 1'b1;
        goto(623);
        bus.isCollide = 1'b0;
        check("hit render1", 16'(bus.isRender1), 16'h0000);
        check("hit render2", 16'(bus.isRender2), 16'h0000);
        check("hit pos1",    bus.position1, xy(40, 56));
        check("hit pos2",    bus.position2, xy(40, 96));
        goto(627); check("hidden render1", 16'(bus.isRender1), 16'h0000);
        goto(628);
        check("respawn render1", 16'(bus.isRender1), 16'h0001);
        check("respawn render2", 16'(bus.isRender2), 16'h0001);
        check("respawn pos1",    bus.position1, xy(40, 56));

        // index change mid-flight
        goto(629);
        bus.index1 = 3'd1;
        goto(630);
        check("idx1 pos1",    bus.position1, xy(72, 40));
        check("idx1 size1",   bus.size1, 16'h1004);
        check("idx1 color1",  16'(bus.color1), 16'h0001);
        check("idx1 render1", 16'(bus.isRender1), 16'h0001);
        check("idx1 pos2",    bus.position2, xy(40, 96));
        check("idx1 size2",   bus.size2, 16'h0808);
        goto(632);
        check("idx1 move pos1", bus.position1, xy(72, 41));
        check("idx1 move pos2", bus.position2, xy(41, 96));
        goto(636); check("idx1 move2 pos1", bus.position1, xy(72, 42));

        // bounce on slot 1, blue on slot 2
        bus.index1 = 3'd4;
        bus.index2 = 3'd3;
        goto(637);
        check("p4 spawn pos1",  bus.position1, xy(104, 40));
        check("p4 size1",       bus.size1, 16'h0808);
        check("p3 spawn pos2",  bus.position2, xy(196, 80));
        check("p3 size2",       bus.size2, 16'h0420);
        check("p3 color2",      16'(bus.color2), 16'h0002);
        goto(640);
        check("p4 step pos1",   bus.position1, xy(104, 42));
        check("p3 step pos2",   bus.position2, xy(194, 80));
        goto(644);  check("p3 step2 pos2", bus.position2, xy(192, 80));
        goto(940);  check("p4 bottom pos1", bus.position1, xy(104, 192));
        goto(944);  check("p4 turn dn pos1", bus.position1, xy(104, 190));
        goto(948);  check("p3 left pos2",   bus.position2, xy(40, 80));
        goto(952);  check("p3 wrap pos2",   bus.position2, xy(196, 80));
        goto(1244); check("p4 top pos1",    bus.position1, xy(104, 40));
        goto(1248); check("p4 turn up pos1", bus.position1, xy(104, 42));

        // disable slot 1
        bus.index1 = 3'd6;
        goto(1249);
        check("dis render1", 16'(bus.isRender1), 16'h0000);
        check("dis pos1",    bus.position1, 16'h0000);
        check("dis size1",   bus.size1, 16'h0000);
        check("dis color1",  16'(bus.color1), 16'h0000);
        check("dis render2", 16'(bus.isRender2), 16'h0001);
        check("dis pos2",    bus.position2, xy(48, 80));

        // pause for 3 clocks
        bus.isRun = 1'b0;
        goto(1250);
        check("pause render2", 16'(bus.isRender2), 16'h0000);
        check("pause pos2",    bus.position2, xy(48, 80));
        goto(1252);
        check("pause3 pos2",    bus.position2, xy(48, 80));
        check("pause3 render1", 16'(bus.isRender1), 16'h0000);
        check("pause3 render2", 16'(bus.isRender2), 16'h0000);
        check("pause3 color2",  16'(bus.color2), 16'h0002);

        bus.isRun  = 1'b1;
        bus.index1 = 3'd0;
        goto(1253);
        check("resume pos1",    bus.position1, xy(40, 56));
        check("resume render1", 16'(bus.isRender1), 16'h0001);
        check("resume pos2",    bus.position2, xy(196, 80));
        check("resume render2", 16'(bus.isRender2), 16'h0001);
        goto(1255);
        check("resume pre tick pos2", bus.position2, xy(196, 80));
        goto(1256);
        check("resume tick pos1", bus.position1, xy(41, 56));
        check("resume tick pos2", bus.position2, xy(194, 80));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
